// File: rtl/instr_fetch_controller.sv
// instr_fetch_controller
//   Generates fetch addresses for a byte-addressed program memory with a
//   1-cycle registered read. It keeps at most one read in flight and buffers
//   returned words in a 2-entry FIFO. The FIFO head is offered to decode over
//   a valid/ready handshake. Branch redirects flush everything in the
//   pipeline. A zero word stops fetch (HALT). A misaligned redirect target
//   locks the block in ERROR until reset.
// Ports:
//   clk, rst       clock and synchronous active-high reset
//   mem_addr       fetch address, driven straight from the fetch PC register
//   mem_data       word read from the address sampled at the previous edge
//   branch_taken   single-cycle redirect request
//   branch_target  redirect byte address
//   instr_valid    FIFO head valid
//   instr_ready    decode accepts the head this cycle
//   instr          FIFO head word (0 when not valid)
//   instr_pc       FIFO head byte address, zero-extended (0 when not valid)
//   halted         fetch stopped on a zero word
//   fetch_error    misaligned redirect target seen
module instr_fetch_controller #(
  parameter int          PC_WIDTH  = 12,
  parameter int          OPD_WIDTH = 32,
  parameter int unsigned RESET_PC  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic [PC_WIDTH-1:0]  mem_addr,
  input  logic [31:0]          mem_data,
  input  logic                 branch_taken,
  input  logic [PC_WIDTH-1:0]  branch_target,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [31:0]          instr,
  output logic [OPD_WIDTH-1:0] instr_pc,
  output logic                 halted,
  output logic                 fetch_error
);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_HALT  = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

  localparam logic [PC_WIDTH-1:0] RESET_PC_W = PC_WIDTH'(RESET_PC);

  state_t              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_WIDTH-1:0] issue_pc_q, issue_pc_d;
  logic                inflight_q, inflight_d;
  logic [1:0]          count_q, count_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic [31:0]         entry_word_q [2];
  logic [31:0]         entry_word_d [2];
  logic [PC_WIDTH-1:0] entry_pc_q [2];
  logic [PC_WIDTH-1:0] entry_pc_d [2];

  logic       pop;
  logic       redirect;
  logic       capture;
  logic       zero_word;
  logic       push;
  logic       issue;
  logic [2:0] occ_sum;

  assign mem_addr    = fetch_pc_q;
  assign instr_valid = (count_q != 2'd0);
  assign instr       = instr_valid ? entry_word_q[rd_ptr_q] : 32'h0;
  assign instr_pc    = instr_valid ? OPD_WIDTH'(entry_pc_q[rd_ptr_q]) : '0;
  assign halted      = (state_q == ST_HALT);
  assign fetch_error = (state_q == ST_ERROR);

  always_comb begin
    pop       = instr_valid & instr_ready;
    redirect  = branch_taken & (state_q != ST_ERROR);
    // A redirect squashes the word returning this cycle.
    capture   = inflight_q & ~redirect;
    zero_word = capture & (mem_data == 32'h0);
    push      = capture & ~zero_word;
    // Slots committed after this edge: buffered + returning - leaving.
    // pop implies count_q >= 1, so this never underflows.
    occ_sum   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
    // A zero-word capture also blocks issue so the address freezes at the
    // word after the halting one.
    issue     = (state_q == ST_FETCH) & ~redirect & ~zero_word & (occ_sum < 3'd2);

    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    issue_pc_d   = issue_pc_q;
    inflight_d   = issue;
    count_d      = count_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    entry_word_d = entry_word_q;
    entry_pc_d   = entry_pc_q;

    if (redirect) begin
      count_d  = 2'd0;
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      if (branch_target[1:0] == 2'b00) begin
        fetch_pc_d = branch_target;
        state_d    = ST_FETCH;
      end else begin
        state_d = ST_ERROR;
      end
    end else begin
      count_d  = count_q + {1'b0, push} - {1'b0, pop};
      rd_ptr_d = rd_ptr_q ^ pop;
      wr_ptr_d = wr_ptr_q ^ push;
      if (push) begin
        entry_word_d[wr_ptr_q] = mem_data;
        entry_pc_d[wr_ptr_q]   = issue_pc_q;
      end
      if (zero_word) begin
        state_d = ST_HALT;
      end
      if (issue) begin
        issue_pc_d = fetch_pc_q;
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(4);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= RESET_PC_W;
      issue_pc_q <= RESET_PC_W;
      inflight_q <= 1'b0;
      count_q    <= 2'd0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      issue_pc_q <= issue_pc_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_entry
    always_ff @(posedge clk) begin
      if (rst) begin
        entry_word_q[gi] <= 32'h0;
        entry_pc_q[gi]   <= '0;
      end else begin
        entry_word_q[gi] <= entry_word_d[gi];
        entry_pc_q[gi]   <= entry_pc_d[gi];
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_controller.sv
module tb_instr_fetch_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] mem_addr;
  logic [31:0] mem_data = 32'h0;
  logic        branch_taken = 1'b0;
  logic [11:0] branch_target = 12'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        halted;
  logic        fetch_error;

  logic [31:0] mem [0:1023];

  int n_checks = 0;
  int n_fail   = 0;

  instr_fetch_controller #(
    .PC_WIDTH (12),
    .OPD_WIDTH(32),
    .RESET_PC (0)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .halted       (halted),
    .fetch_error  (fetch_error)
  );

  always #5 clk = ~clk;

  // Program memory: registered read, one cycle latency.
  always @(posedge clk) mem_data <= mem[mem_addr[11:2]];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_branch(input logic [11:0] target);
    branch_taken  = 1'b1;
    branch_target = target;
    tick();
    branch_taken = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", instr_valid); end
    n_checks++; if (instr !== 32'h0) begin n_fail++; $display("FAIL reset_instr got=%h exp=0", instr); end
    n_checks++; if (instr_pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got=%h exp=0", instr_pc); end
    n_checks++; if (mem_addr !== 12'h0) begin n_fail++; $display("FAIL reset_mem_addr got=%h exp=0", mem_addr); end
    n_checks++; if (halted !== 1'b0) begin n_fail++; $display("FAIL reset_halted got=%b exp=0", halted); end
    n_checks++; if (fetch_error !== 1'b0) begin n_fail++; $display("FAIL reset_error got=%b exp=0", fetch_error); end
  endtask

  // Release reset with ready high: first valid after the 2nd edge, then 0/4/8.
  task automatic test_stream();
    instr_ready = 1'b1;
    rst = 1'b0;
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL stream_latency got=%b exp=0", instr_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== mem[k]) begin
        n_fail++;
        $display("FAIL stream_%0d got v=%b pc=%h w=%h exp pc=%h w=%h", k, instr_valid, instr_pc, instr, 4 * k, mem[k]);
      end
      $display("stream pop pc=%h instr=%h", instr_pc, instr);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    instr_ready = 1'b0;
    repeat (5) tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL bp_hold got v=%b pc=%h exp v=1 pc=0", instr_valid, instr_pc); end
    n_checks++; if (mem_addr !== 12'd8) begin n_fail++; $display("FAIL bp_mem_addr got=%0d exp=8", mem_addr); end
    instr_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'(4 * k) || instr !== mem[k]) begin
        n_fail++;
        $display("FAIL bp_drain_%0d got v=%b pc=%h exp pc=%h", k, instr_valid, instr_pc, 4 * k);
      end
      $display("bp pop pc=%h instr=%h", instr_pc, instr);
      tick();
    end
  endtask

  task automatic test_redirect();
    do_reset();
    instr_ready = 1'b0;
    repeat (4) tick();
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd4) begin n_fail++; $display("FAIL br_setup got v=%b pc=%h exp pc=4", instr_valid, instr_pc); end
    instr_ready = 1'b1;
    do_branch(12'd104);
    instr_ready = 1'b0;
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush got=%b exp=0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL br_gap got=%b exp=0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd104 || instr !== mem[26]) begin n_fail++; $display("FAIL br_first got v=%b pc=%h w=%h exp pc=104", instr_valid, instr_pc, instr); end
    instr_ready = 1'b1;
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd108 || instr !== mem[27]) begin n_fail++; $display("FAIL br_second got v=%b pc=%h exp pc=108", instr_valid, instr_pc); end
  endtask

  task automatic test_halt();
    instr_ready = 1'b1;
    do_branch(12'd196);
    tick();
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd196) begin n_fail++; $display("FAIL halt_196 got v=%b pc=%h", instr_valid, instr_pc); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd200) begin n_fail++; $display("FAIL halt_200 got v=%b pc=%h", instr_valid, instr_pc); end
    tick();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 12'd208) begin n_fail++; $display("FAIL halt_stop got h=%b v=%b addr=%0d exp h=1 v=0 addr=208", halted, instr_valid, mem_addr); end
    repeat (3) tick();
    n_checks++; if (halted !== 1'b1 || instr_valid !== 1'b0 || mem_addr !== 12'd208) begin n_fail++; $display("FAIL halt_hold got h=%b v=%b addr=%0d", halted, instr_valid, mem_addr); end
    do_branch(12'd140);
    n_checks++; if (halted !== 1'b0 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL halt_clear got h=%b v=%b exp 0 0", halted, instr_valid); end
    tick();
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'd140) begin n_fail++; $display("FAIL halt_resume got v=%b pc=%h exp pc=140", instr_valid, instr_pc); end
  endtask

  task automatic test_error();
    instr_ready = 1'b1;
    do_branch(12'h062);
    n_checks++; if (fetch_error !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL err_set got e=%b v=%b exp 1 0", fetch_error, instr_valid); end
    do_branch(12'h000);
    tick();
    tick();
    n_checks++; if (fetch_error !== 1'b1 || instr_valid !== 1'b0) begin n_fail++; $display("FAIL err_sticky got e=%b v=%b exp 1 0", fetch_error, instr_valid); end
    do_reset();
    n_checks++; if (fetch_error !== 1'b0 || instr_valid !== 1'b0 || mem_addr !== 12'h0) begin n_fail++; $display("FAIL err_reset got e=%b v=%b addr=%h", fetch_error, instr_valid, mem_addr); end
    tick();
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin n_fail++; $display("FAIL err_restart got v=%b pc=%h exp pc=0", instr_valid, instr_pc); end
  endtask

  task automatic test_reset_midstream();
    instr_ready = 1'b0;
    repeat (3) tick();
    n_checks++; if (instr_valid !== 1'b1) begin n_fail++; $display("FAIL mid_full got v=%b exp 1", instr_valid); end
    do_reset();
    n_checks++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || mem_addr !== 12'h0 || halted !== 1'b0 || fetch_error !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset got v=%b w=%h pc=%h addr=%h h=%b e=%b", instr_valid, instr, instr_pc, mem_addr, halted, fetch_error);
    end
    tick();
    n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL mid_latency got v=%b exp 0", instr_valid); end
    tick();
    n_checks++; if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== mem[0]) begin n_fail++; $display("FAIL mid_restart got v=%b pc=%h", instr_valid, instr_pc); end
  endtask

  task automatic test_wrap();
    logic [11:0] exp_pcs [3];
    exp_pcs[0] = 12'd4092;
    exp_pcs[1] = 12'd0;
    exp_pcs[2] = 12'd4;
    instr_ready = 1'b1;
    do_branch(12'd4092);
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== {20'h0, exp_pcs[k]} || instr !== mem[exp_pcs[k][11:2]]) begin
        n_fail++;
        $display("FAIL wrap_%0d got v=%b pc=%h exp pc=%h", k, instr_valid, instr_pc, exp_pcs[k]);
      end
    end
  endtask

  // Scoreboard: decode must see the program in address order from the last
  // redirect target, each word equal to memory, with no gaps or repeats.
  task automatic test_random();
    logic [11:0] exp_pc;
    logic [11:0] tgt;
    logic        flushed;
    int          stall;
    mem[51] = 32'h0000_a013;
    tgt = 12'(4 * $urandom_range(0, 1023));
    instr_ready = 1'b1;
    do_branch(tgt);
    exp_pc  = tgt;
    flushed = 1'b1;
    stall   = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (flushed) begin
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rnd_flush cyc=%0d got v=%b exp 0", cyc, instr_valid); end
      end
      flushed = 1'b0;
      stall = instr_valid ? 0 : stall + 1;
      n_checks++; if (stall > 2) begin n_fail++; $display("FAIL rnd_stall cyc=%0d got %0d idle cycles exp <=2", cyc, stall); end
      instr_ready = ($urandom_range(0, 3) != 0);
      if (instr_valid && instr_ready) begin
        n_checks++;
        if (instr_pc !== {20'h0, exp_pc} || instr !== mem[exp_pc[11:2]]) begin
          n_fail++;
          $display("FAIL rnd_pop cyc=%0d got pc=%h w=%h exp pc=%h w=%h", cyc, instr_pc, instr, exp_pc, mem[exp_pc[11:2]]);
        end
        $display("rnd pop pc=%h instr=%h", instr_pc, instr);
        exp_pc = exp_pc + 12'd4;
      end
      if ($urandom_range(0, 19) == 0) begin
        tgt = 12'(4 * $urandom_range(0, 1023));
        branch_taken  = 1'b1;
        branch_target = tgt;
        exp_pc  = tgt;
        flushed = 1'b1;
        stall   = -2;
      end else begin
        branch_taken = 1'b0;
      end
      tick();
    end
    branch_taken = 1'b0;
    instr_ready  = 1'b0;
    repeat (4) tick();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== {20'h0, exp_pc} || mem_addr !== exp_pc + 12'd8) begin
      n_fail++;
      $display("FAIL rnd_fill got v=%b pc=%h addr=%h exp pc=%h addr=%h", instr_valid, instr_pc, mem_addr, exp_pc, exp_pc + 12'd8);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0000_0013 + (i << 12);
    mem[0]  = 32'h0041_8133;
    mem[1]  = 32'h0051_8133;
    mem[2]  = 32'h0041_8113;
    mem[51] = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_error();
    test_reset_midstream();
    test_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
